float_to_int_pipe: RTL

Parametrised, pipelined floating-point to signed-integer converter with valid/ready handshakes on both sides. Generalises the combinational single-precision converter to arbitrary exponent, mantissa and integer widths, and adds four rounding modes and saturation. It also raises the same status flags: denorm, p_lost and invalid. It sits between FP producers and integer datapaths, with one result per clock at full throughput.

---
 rtl/float_to_int_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/float_to_int_pipe.sv
// float_to_int_pipe: two-stage FP to signed-int converter with 4 rounding modes, saturation and status flags; FTOI_STICKY_FLAGS_EN adds sticky flags
module float_to_int_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_fp,
  input  logic [1:0]             in_rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_int,
  output logic                   out_denorm,
  output logic                   out_p_lost,
`ifdef FTOI_STICKY_FLAGS_EN
  output logic                   out_invalid,
  input  logic                   flags_clr,
  output logic                   sticky_denorm,
  output logic                   sticky_p_lost,
  output logic                   sticky_invalid
`else
  output logic                   out_invalid
`endif
);
  localparam int EW = EXP_W + 2;
  localparam int W = (INT_W > MAN_W + 2 ? INT_W : MAN_W + 2) + 1;
  localparam int F = MAN_W + 2;
  localparam int V = W + F;
  localparam int SH_W = $clog2(INT_W + 2);
  localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] E_HI = EW'(INT_W);
  localparam logic signed [EW-1:0] E_LO = EW'(-2);
  localparam logic signed [EW-1:0] E_TWO = EW'(2);
  localparam logic [2:0] C_ZERO = 3'd0, C_SUB = 3'd1, C_NORM = 3'd2, C_INF = 3'd3, C_NAN = 3'd4;
  localparam logic [INT_W-1:0] MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [W-1:0] LIM = {{(W-INT_W){1'b0}}, 1'b1, {(INT_W-1){1'b0}}};

  // big: |value| >= 2^INT_W, always out of range; tiny: E < -2, only sticky survives
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [2:0]        cls;
    logic [1:0]        rmode;
    logic [MAN_W-1:0]  frac;
    logic              big;
    logic              tiny;
    logic [SH_W-1:0]   sh;
  } s1_t;

  s1_t s1_d, s1_q;
  logic s2_load;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;
  logic signed [EW-1:0] e;
  logic [V-1:0] fixed;
  logic [W-1:0] int_part, mag;
  logic guard, sticky, inexact, inc, ovf;
  logic [INT_W-1:0] res, sat, sub_res;
  logic out_valid_d, out_valid_q, out_denorm_d, out_denorm_q;
  logic out_p_lost_d, out_p_lost_q, out_invalid_d, out_invalid_q;
  logic [INT_W-1:0] out_int_d, out_int_q;

  // S1: handshake, operand classification, unbiased exponent and left-shift amount (E+2)
  always_comb begin
    s2_load = !out_valid_q | out_ready;
    in_ready = !s1_q.valid | s2_load;
    exp_f = in_fp[EXP_W+MAN_W-1:MAN_W];
    frac_f = in_fp[MAN_W-1:0];
    e = $signed({2'b00, exp_f}) - BIAS;
    s1_d = s1_q;
    s1_d.valid = in_ready ? in_valid : s1_q.valid;
    if (in_valid && in_ready) begin
      s1_d.sign = in_fp[EXP_W+MAN_W];
      s1_d.cls = exp_f == '0 ? (frac_f == '0 ? C_ZERO : C_SUB) : (&exp_f) ? (frac_f == '0 ? C_INF : C_NAN) : C_NORM;
      s1_d.rmode = in_rmode;
      s1_d.frac = frac_f;
      s1_d.big = e >= E_HI;
      s1_d.tiny = e < E_LO;
      s1_d.sh = SH_W'(e + E_TWO);
    end
  end

  // S2: align into fixed point with F fraction bits, round, saturate, negate, select by class
  always_comb begin
    fixed = V'({1'b1, s1_q.frac}) << s1_q.sh;
    int_part = s1_q.tiny ? '0 : fixed[V-1:F];
    guard = !s1_q.tiny & fixed[F-1];
    sticky = s1_q.tiny | (|fixed[F-2:0]);
    inexact = guard | sticky;
    inc = s1_q.rmode == 2'b01 ? guard & (sticky | int_part[0]) :
          s1_q.rmode == 2'b10 ? !s1_q.sign & inexact :
          s1_q.rmode == 2'b11 ? s1_q.sign & inexact : 1'b0;
    mag = int_part + {{(W-1){1'b0}}, inc};
    ovf = s1_q.big | ((|mag[W-1:INT_W-1]) & !(s1_q.sign & mag == LIM));
    res = s1_q.sign ? -mag[INT_W-1:0] : mag[INT_W-1:0];
    sat = s1_q.sign ? MIN : MAX;
    sub_res = (s1_q.rmode == 2'b10 && !s1_q.sign) ? INT_W'(1) : (s1_q.rmode == 2'b11 && s1_q.sign) ? '1 : '0;
    out_valid_d = s2_load ? s1_q.valid : out_valid_q;
    out_int_d = out_int_q;
    out_denorm_d = out_denorm_q;
    out_p_lost_d = out_p_lost_q;
    out_invalid_d = out_invalid_q;
    if (s2_load && s1_q.valid) begin
      out_int_d = s1_q.cls == C_NAN ? MIN : s1_q.cls == C_INF ? sat : s1_q.cls == C_SUB ? sub_res :
                  s1_q.cls == C_ZERO ? '0 : ovf ? sat : res;
      out_invalid_d = s1_q.cls == C_NAN || s1_q.cls == C_INF || (s1_q.cls == C_NORM && ovf);
      out_denorm_d = s1_q.cls == C_SUB;
      out_p_lost_d = s1_q.cls == C_SUB || (s1_q.cls == C_NORM && !ovf && inexact);
    end
  end

  // pipeline registers; reset drops any in-flight operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      out_valid_q <= 1'b0;
      out_int_q <= '0;
      out_denorm_q <= 1'b0;
      out_p_lost_q <= 1'b0;
      out_invalid_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      out_valid_q <= out_valid_d;
      out_int_q <= out_int_d;
      out_denorm_q <= out_denorm_d;
      out_p_lost_q <= out_p_lost_d;
      out_invalid_q <= out_invalid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_int = out_int_q;
  assign out_denorm = out_denorm_q;
  assign out_p_lost = out_p_lost_q;
  assign out_invalid = out_invalid_q;

`ifdef FTOI_STICKY_FLAGS_EN
  logic [2:0] sticky_d, sticky_q;
  // accumulate flags on each delivered result; clear beats a simultaneous set
  always_comb sticky_d = flags_clr ? 3'b000 : sticky_q | ({out_denorm_q, out_p_lost_q, out_invalid_q} & {3{out_valid_q & out_ready}});
  // sticky flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 3'b000;
    else sticky_q <= sticky_d;
  end
  assign sticky_denorm = sticky_q[2];
  assign sticky_p_lost = sticky_q[1];
  assign sticky_invalid = sticky_q[0];
`endif
endmodule
